// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage between the PC register and decode.
//   Issues pc_i to instruction memory over a req/gnt port, collects in-order
//   responses of any latency, and buffers {pc, instr} pairs in a DEPTH-entry
//   queue presented to decode over a valid/ready handshake. A redirect flush
//   empties the queue and counts the still-outstanding responses so they are
//   discarded when they eventually return.
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   pc_i, flush_i     current PC and redirect strobe from the PC stage
//   fetch_stall_o     1 = hold the PC (no request accepted this cycle)
//   imem_req_o/addr_o fetch request and address; imem_gnt_i accepts it
//   imem_rvalid_i/rdata_i  in-order fetch responses
//   id_valid_o/ready_i     decode handshake; id_pc_o/id_instr_o head entry
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            fetch_stall_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_instr_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   FULL = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [AW-1:0] AONE = AW'(1);
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [AW-1:0]   rd_ptr, fill_ptr, wr_ptr;
    logic [CW-1:0]   n_res, n_fill, drop_cnt, pending;
    logic            accept, drop, fill, pop, resp_taken;

    assign pending       = n_res - n_fill;
    // Credit covers both live slots and responses still owed from before a flush.
    assign imem_req_o    = ~RESET & ~flush_i & (({1'b0, n_res} + {1'b0, drop_cnt}) < FULL);
    assign imem_addr_o   = pc_i;
    assign accept        = imem_req_o & imem_gnt_i;
    assign fetch_stall_o = ~accept;
    assign drop          = imem_rvalid_i & (drop_cnt != '0);
    assign fill          = imem_rvalid_i & (drop_cnt == '0) & (pending != '0) & ~flush_i;
    // A response in the flush cycle retires one outstanding fetch, unless nothing is owed.
    assign resp_taken    = imem_rvalid_i & ((drop_cnt != '0) | (pending != '0));
    assign id_valid_o    = n_fill != '0;
    assign pop           = id_valid_o & id_ready_i & ~flush_i;
    assign id_pc_o       = pc_q[rd_ptr];
    assign id_instr_o    = instr_q[rd_ptr];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr   <= '0;
            fill_ptr <= '0;
            wr_ptr   <= '0;
            n_res    <= '0;
            n_fill   <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                pc_q[wr_ptr] <= pc_i;
                wr_ptr       <= wr_ptr + AONE;
            end
            if (fill)
                instr_q[fill_ptr] <= imem_rdata_i;
            if (flush_i) begin
                rd_ptr   <= wr_ptr;
                fill_ptr <= wr_ptr;
                n_res    <= '0;
                n_fill   <= '0;
                drop_cnt <= drop_cnt + pending - (resp_taken ? ONE : '0);
            end else begin
                rd_ptr   <= rd_ptr + (pop ? AONE : '0);
                fill_ptr <= fill_ptr + (fill ? AONE : '0);
                n_res    <= n_res + (accept ? ONE : '0) - (pop ? ONE : '0);
                n_fill   <= n_fill + (fill ? ONE : '0) - (pop ? ONE : '0);
                drop_cnt <= drop_cnt - (drop ? ONE : '0);
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed bench for if_fetch_queue with a PC register
//   and a fixed-latency in-order instruction memory driven from the stimulus tasks.
module tb_if_fetch_queue;
    logic        CLK = 1'b0;
    logic        RESET, flush_i, imem_gnt_i, imem_rvalid_i, id_ready_i;
    logic [31:0] pc_i, imem_rdata_i;
    logic        fetch_stall_o, imem_req_o, id_valid_o;
    logic [31:0] imem_addr_o, id_pc_o, id_instr_o;
    logic [31:0] tgt;
    int          lat, cyc, tests, fails;
    int          n, acc, resp, pops, maxo;
    logic [31:0] epc;

    typedef struct {
        logic [31:0] pc;
        int          due;
    } req_t;
    req_t mq[$];

    if_fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET), .pc_i(pc_i), .flush_i(flush_i),
        .fetch_stall_o(fetch_stall_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o), .id_instr_o(id_instr_o)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return p ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: PC register update, memory request capture and response drive.
    task automatic tick();
        logic        a, r;
        logic [31:0] nxt;
        #1;
        a   = imem_req_o & imem_gnt_i;
        r   = RESET;
        nxt = flush_i ? tgt : (fetch_stall_o ? pc_i : pc_i + 32'd4);
        if (r) mq.delete();
        else if (a) mq.push_back('{pc: pc_i, due: cyc + lat});
        @(posedge CLK);
        cyc++;
        #1;
        pc_i = r ? 32'h0 : nxt;
        if (!r && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = instr_of(mq[0].pc);
            void'(mq.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        #1;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; lat = 1; tgt = 32'h0;
        RESET = 1'b1; flush_i = 1'b0; imem_gnt_i = 1'b0; id_ready_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; pc_i = 32'h0;
        tick(); tick();
        #1;
        chk("rst_stall", 32'(fetch_stall_o), 1);
        chk("rst_req", 32'(imem_req_o), 0);
        chk("rst_valid", 32'(id_valid_o), 0);
        chk("rst_pc", id_pc_o, 0);
        chk("rst_instr", id_instr_o, 0);

        // zero-latency memory, decode always ready
        RESET = 1'b0; imem_gnt_i = 1'b1; id_ready_i = 1'b1; #1;
        chk("zl_req", 32'(imem_req_o), 1);
        chk("zl_addr", imem_addr_o, 0);
        chk("zl_stall0", 32'(fetch_stall_o), 0);
        tick();
        chk("zl_latency", 32'(id_valid_o), 0);
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("zl_valid", 32'(id_valid_o), 1);
            chk("zl_pc", id_pc_o, 32'(4 * k));
            chk("zl_instr", id_instr_o, instr_of(32'(4 * k)));
            chk("zl_stall", 32'(fetch_stall_o), 0);
            tick();
        end

        // decode blocked: queue fills to DEPTH, then drains in order
        RESET = 1'b1; tick();
        RESET = 1'b0; id_ready_i = 1'b0; #1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (imem_req_o && imem_gnt_i) n++;
            tick();
        end
        chk("full_accepts", 32'(n), 4);
        chk("full_req", 32'(imem_req_o), 0);
        chk("full_stall", 32'(fetch_stall_o), 1);
        chk("full_head", id_pc_o, 0);
        id_ready_i = 1'b1; #1;
        chk("drain_pc0", id_pc_o, 32'h0);
        chk("drain_req0", 32'(imem_req_o), 0);
        tick();
        chk("drain_pc4", id_pc_o, 32'h4);
        chk("resume_req", 32'(imem_req_o), 1);
        chk("resume_addr", imem_addr_o, 32'h10);
        tick();
        chk("drain_pc8", id_pc_o, 32'h8);
        tick();
        chk("drain_pc12", id_pc_o, 32'hC);
        tick();
        chk("resume_pc16", id_pc_o, 32'h10);
        chk("resume_instr16", id_instr_o, instr_of(32'h10));

        // 3-cycle latency with continuous grant
        RESET = 1'b1; tick();
        RESET = 1'b0; lat = 3; id_ready_i = 1'b1; imem_gnt_i = 1'b1; #1;
        acc = 0; resp = 0; pops = 0; maxo = 0; epc = 32'h0;
        for (int k = 0; k < 40; k++) begin
            if (k == 30) begin imem_gnt_i = 1'b0; #1; end
            if (imem_req_o && imem_gnt_i) acc++;
            if (imem_rvalid_i) resp++;
            if (acc - resp > maxo) maxo = acc - resp;
            if (id_valid_o && id_ready_i) begin
                chk("lat3_pc", id_pc_o, epc);
                chk("lat3_instr", id_instr_o, instr_of(epc));
                epc = epc + 32'd4;
                pops++;
            end
            tick();
        end
        chk("lat3_maxout", 32'(maxo <= 4), 1);
        chk("lat3_progress", 32'(acc >= 20), 1);
        chk("lat3_nolost", 32'(pops), 32'(acc));
        chk("lat3_pcadv", pc_i, 32'(4 * acc));

        // flush with two fetches in flight
        RESET = 1'b1; tick();
        RESET = 1'b0; lat = 3; imem_gnt_i = 1'b1; id_ready_i = 1'b1;
        flush_i = 1'b1; tgt = 32'h10; #1;
        chk("fl_req", 32'(imem_req_o), 0);
        chk("fl_stall", 32'(fetch_stall_o), 1);
        tick();
        flush_i = 1'b0; #1;
        chk("fl_addr10", imem_addr_o, 32'h10);
        tick();
        chk("fl_addr14", imem_addr_o, 32'h14);
        tick();
        flush_i = 1'b1; tgt = 32'h100; #1;
        chk("fl2_req", 32'(imem_req_o), 0);
        chk("fl2_stall", 32'(fetch_stall_o), 1);
        tick();
        flush_i = 1'b0; #1;
        chk("fl2_req_after", 32'(imem_req_o), 1);
        chk("fl2_addr", imem_addr_o, 32'h100);
        for (int k = 0; k < 4; k++) begin
            chk("fl2_dropped", 32'(id_valid_o), 0);
            tick();
        end
        chk("fl2_valid", 32'(id_valid_o), 1);
        chk("fl2_pc", id_pc_o, 32'h100);
        chk("fl2_instr", id_instr_o, instr_of(32'h100));

        // flush coincident with a response and a ready head entry
        RESET = 1'b1; tick();
        RESET = 1'b0; lat = 2; imem_gnt_i = 1'b1; id_ready_i = 1'b1; #1;
        tick(); tick(); tick();
        flush_i = 1'b1; tgt = 32'h200; #1;
        chk("fc_head_valid", 32'(id_valid_o), 1);
        chk("fc_req", 32'(imem_req_o), 0);
        chk("fc_stall", 32'(fetch_stall_o), 1);
        tick();
        flush_i = 1'b0; #1;
        chk("fc_addr", imem_addr_o, 32'h200);
        for (int k = 0; k < 3; k++) begin
            chk("fc_dropped", 32'(id_valid_o), 0);
            tick();
        end
        chk("fc_valid", 32'(id_valid_o), 1);
        chk("fc_pc", id_pc_o, 32'h200);
        chk("fc_instr", id_instr_o, instr_of(32'h200));

        // reset with entries queued
        id_ready_i = 1'b0; #1;
        tick(); tick(); tick();
        chk("mr_queued", 32'(id_valid_o), 1);
        RESET = 1'b1; #1;
        chk("mr_stall", 32'(fetch_stall_o), 1);
        chk("mr_req", 32'(imem_req_o), 0);
        tick();
        RESET = 1'b0; id_ready_i = 1'b1; #1;
        chk("mr_valid", 32'(id_valid_o), 0);
        chk("mr_pc", id_pc_o, 0);
        chk("mr_instr", id_instr_o, 0);
        chk("mr_req_after", 32'(imem_req_o), 1);
        chk("mr_addr", imem_addr_o, 0);
        tick(); tick(); tick();
        chk("mr_first_valid", 32'(id_valid_o), 1);
        chk("mr_first_pc", id_pc_o, 0);
        chk("mr_first_instr", id_instr_o, instr_of(32'h0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Issues the current PC to instruction memory over a request/grant port, accepts in-order responses with variable latency, and buffers {pc, instr} pairs in a DEPTH-entry queue that feeds decode over a valid/ready handshake.
- Drives the fetch stall back into the PC hazard path; the PC advances only when a request is accepted.
- Discards all queued and in-flight fetches on a redirect flush.

Parameters:
DEPTH, 4, queue entries and maximum outstanding requests; power of 2, >=2
XLEN, 32, PC and instruction width

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous reset, active-high
pc_i  input  XLEN  current PC from the PC register
flush_i  input  1  redirect (branch/jump taken); PC takes its new value at the same edge
fetch_stall_o  output  1  to PC hazard input; 1 = hold PC
imem_req_o  output  1  fetch request valid
imem_addr_o  output  XLEN  fetch address (= pc_i)
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response valid; responses return in request order
imem_rdata_i  input  XLEN  fetched instruction
id_valid_o  output  1  head entry holds a valid instruction
id_ready_i  input  1  decode accepts the head entry
id_pc_o  output  XLEN  PC of the head entry
id_instr_o  output  XLEN  instruction of the head entry

Behaviour:
- State:
  - Slot array pc[DEPTH], instr[DEPTH].
  - Pointers rd_ptr, fill_ptr, wr_ptr, each clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Counters n_res (reserved slots, 0..DEPTH), n_fill (filled slots, 0..DEPTH), drop_cnt (0..DEPTH).
  - Invariant: n_fill <= n_res <= DEPTH. Pending count = n_res - n_fill.
- Reset (synchronous, RESET=1 at a rising edge):
  - All pointers and counters and all slot contents go to 0.
  - Outputs: id_valid_o=0, id_pc_o=0, id_instr_o=0, imem_req_o=0.
  - fetch_stall_o=1 while RESET is high.
  - A reset asserted mid-operation abandons outstanding responses. The memory side is reset by the same RESET.
- Issue:
  - imem_req_o = ~RESET & ~flush_i & (n_res + drop_cnt < DEPTH).
  - imem_addr_o = pc_i.
  - accept = imem_req_o & imem_gnt_i.
  - On accept: pc[wr_ptr] <= pc_i, wr_ptr++, n_res++.
  - fetch_stall_o = ~accept (combinational). The PC advances exactly once per accepted request.
- Response, when imem_rvalid_i=1:
  - If drop_cnt > 0: discard the response, drop_cnt--.
  - Else if pending > 0: instr[fill_ptr] <= imem_rdata_i, fill_ptr++, n_fill++.
  - Else: protocol violation; ignore the response, no state change.
- Decode side:
  - id_valid_o = (n_fill > 0).
  - id_pc_o = pc[rd_ptr]; id_instr_o = instr[rd_ptr].
  - pop = id_valid_o & id_ready_i & ~flush_i.
  - On pop: rd_ptr++, n_res--, n_fill--.
- Timing:
  - A response arriving at edge N is visible on id_* at the output after edge N; minimum request-to-decode latency is 1 cycle after rvalid.
  - No combinational path from imem_rvalid_i to id_valid_o.
- Simultaneous events: issue, fill and pop may all happen in the same cycle. Counters update by their net change, e.g. issue+pop leaves n_res unchanged.
- Full: when n_res + drop_cnt == DEPTH, imem_req_o=0 and fetch_stall_o=1 until a pop or a drop frees credit.
- Flush (flush_i=1 at an edge):
  - rd_ptr, fill_ptr and wr_ptr all move to wr_ptr; n_res=0, n_fill=0.
  - drop_cnt <= drop_cnt + pending − (1 if imem_rvalid_i that cycle).
  - No request is issued and no pop occurs in the flush cycle; fetch_stall_o=1 in that cycle, so the PC takes the target via Mux_pc.
  - The first request after the flush carries the target PC.
- Back-to-back flushes accumulate drop_cnt correctly; drop_cnt never exceeds DEPTH.

Test Plan:
- Reset then zero-latency memory (gnt=1 and rvalid the next cycle), id_ready_i=1, PC incrementing by 4 -> id_pc_o = 0,4,8,… one per cycle after pipeline fill, id_instr_o matches memory, fetch_stall_o=0 in steady state.
- id_ready_i=0 with DEPTH=4 -> exactly 4 requests accepted, then imem_req_o=0 and fetch_stall_o=1. Release ready -> entries drain in order 0,4,8,12 and issue resumes at 16.
- Response latency 3 cycles, gnt=1 continuously -> no more than 4 outstanding, ordering preserved, no lost or duplicated PC.
- 2 requests in flight (PC 0x10, 0x14), flush_i for one cycle with target 0x100 -> both late responses discarded (drop_cnt 2→0), first delivered entry is pc=0x100.
- Flush coincident with rvalid and with id_ready_i=1 -> no pop, that response counted as dropped, drop_cnt = pending−1.
- Assert RESET mid-stream with entries queued -> next cycle id_valid_o=0, all counters 0, first post-reset request has imem_addr_o=0.
